// File: rtl/div_check_pkg.sv
// Purpose : shared widths and FSM state encoding for the divider result checker.
// Latency : n/a (declarations only).
// Backpressure : n/a.
package div_check_pkg;

   localparam int N_W_DEF   = 16;  // dividend width
   localparam int D_W_DEF   = 8;   // divisor / quotient / remainder width
   localparam int SUM_W_DEF = 24;  // error accumulator width

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/abs_diff.sv
// Purpose : unsigned |a - b| plus a flag telling whether b exceeds a.
// Latency : combinational.
// Backpressure : none.
// Ports   : a, b (W-bit operands) -> diff (W-bit magnitude), over (b > a).
module abs_diff #(
   parameter int W = 16
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] diff,
   output logic         over
);

   // Larger minus smaller, so the magnitude never wraps.
   always_comb begin
      over = (b > a);
      diff = over ? (b - a) : (a - b);
   end

endmodule

// File: rtl/divider_result_checker.sv
// Purpose : rebuilds q*d+r from a divider's outputs, compares it with the original dividend, keeps error stats.
// Latency : result valid 8 cycles after the accept edge (one shift-add step per quotient bit).
// Backpressure : single operand set in flight; in_ready low until the result is consumed via out_ready.
// Ports   : clk/rst_n; in_valid/in_ready + n,d,q,r operand set; out_valid/out_ready + n_hat, err, over,
//           div_zero result; stat_clr clears err_sum (saturating error sum) and sample_cnt (saturating count).
module divider_result_checker
   import div_check_pkg::*;
#(
   parameter int N_W   = N_W_DEF,
   parameter int D_W   = D_W_DEF,
   parameter int SUM_W = SUM_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N_W-1:0]   n,
   input  logic [D_W-1:0]   d,
   input  logic [D_W-1:0]   q,
   input  logic [D_W-1:0]   r,
   input  logic             stat_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N_W-1:0]   n_hat,
   output logic [N_W-1:0]   err,
   output logic             over,
   output logic             div_zero,
   output logic [SUM_W-1:0] err_sum,
   output logic [15:0]      sample_cnt
);

   localparam int CNT_W = (D_W > 1) ? $clog2(D_W) : 1;
   localparam int SUM_X = SUM_W + 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(D_W - 1);

   state_t           state_q,      state_d;
   logic [N_W-1:0]   n_cap_q,      n_cap_d;
   logic [D_W-1:0]   d_cap_q,      d_cap_d;
   logic [D_W-1:0]   q_cap_q,      q_cap_d;
   logic [N_W-1:0]   acc_q,        acc_d;
   logic [CNT_W-1:0] step_q,       step_d;
   logic [N_W-1:0]   n_hat_q,      n_hat_d;
   logic [N_W-1:0]   err_q,        err_d;
   logic             over_q,       over_d;
   logic             div_zero_q,   div_zero_d;
   logic             out_valid_q,  out_valid_d;
   logic [SUM_W-1:0] err_sum_q,    err_sum_d;
   logic [15:0]      sample_cnt_q, sample_cnt_d;

   logic [N_W-1:0]   d_ext;
   logic [N_W-1:0]   partial;
   logic [N_W-1:0]   acc_add;
   logic [N_W-1:0]   diff_w;
   logic             over_w;
   logic             handshake;
   logic [SUM_X-1:0] sum_ext;

   assign in_ready   = (state_q == IDLE);
   assign out_valid  = out_valid_q;
   assign n_hat      = n_hat_q;
   assign err        = err_q;
   assign over       = over_q;
   assign div_zero   = div_zero_q;
   assign err_sum    = err_sum_q;
   assign sample_cnt = sample_cnt_q;

   // One shift-add step: the current quotient bit selects d << step.
   // The accumulator starts at r, so after the last step it holds q*d + r.
   always_comb begin
      d_ext   = {{(N_W-D_W){1'b0}}, d_cap_q};
      partial = d_ext << step_q;
      acc_add = q_cap_q[step_q] ? (acc_q + partial) : acc_q;
   end

   // Compare against the value the accumulator takes on the final step,
   // so the result registers can load in that same edge.
   abs_diff #(.W(N_W)) u_abs_diff (
      .a    (n_cap_q),
      .b    (acc_add),
      .diff (diff_w),
      .over (over_w)
   );

   assign handshake = out_valid_q & out_ready;
   assign sum_ext   = {1'b0, err_sum_q} + SUM_X'(err_q);

   always_comb begin
      state_d      = state_q;
      n_cap_d      = n_cap_q;
      d_cap_d      = d_cap_q;
      q_cap_d      = q_cap_q;
      acc_d        = acc_q;
      step_d       = step_q;
      n_hat_d      = n_hat_q;
      err_d        = err_q;
      over_d       = over_q;
      div_zero_d   = div_zero_q;
      out_valid_d  = out_valid_q;
      err_sum_d    = err_sum_q;
      sample_cnt_d = sample_cnt_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               n_cap_d = n;
               d_cap_d = d;
               q_cap_d = q;
               acc_d   = {{(N_W-D_W){1'b0}}, r};
               step_d  = '0;
               state_d = MUL;
            end
         end
         MUL: begin
            acc_d  = acc_add;
            step_d = step_q + CNT_W'(1);
            if (step_q == LAST_STEP) begin
               n_hat_d     = acc_add;
               err_d       = diff_w;
               over_d      = over_w;
               div_zero_d  = (d_cap_q == '0);
               out_valid_d = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            // Results stay put until consumed; the return to IDLE costs a
            // cycle, so a new operand set is never taken on the handshake edge.
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
         end
      endcase

      // A clear request overrides the handshake update in the same cycle.
      if (stat_clr) begin
         err_sum_d    = '0;
         sample_cnt_d = '0;
      end else if (handshake) begin
         err_sum_d    = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
         sample_cnt_d = (sample_cnt_q == 16'hFFFF) ? sample_cnt_q : (sample_cnt_q + 16'd1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         n_cap_q      <= '0;
         d_cap_q      <= '0;
         q_cap_q      <= '0;
         acc_q        <= '0;
         step_q       <= '0;
         n_hat_q      <= '0;
         err_q        <= '0;
         over_q       <= 1'b0;
         div_zero_q   <= 1'b0;
         out_valid_q  <= 1'b0;
         err_sum_q    <= '0;
         sample_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         n_cap_q      <= n_cap_d;
         d_cap_q      <= d_cap_d;
         q_cap_q      <= q_cap_d;
         acc_q        <= acc_d;
         step_q       <= step_d;
         n_hat_q      <= n_hat_d;
         err_q        <= err_d;
         over_q       <= over_d;
         div_zero_q   <= div_zero_d;
         out_valid_q  <= out_valid_d;
         err_sum_q    <= err_sum_d;
         sample_cnt_q <= sample_cnt_d;
      end
   end

endmodule
